// File: rtl/dtcm_ctrl.sv
// DTCM controller: LSU command/response channel to a single-port, one-cycle-read SRAM.
// Define DTCM_RSP_FIFO_EN for a two-entry response FIFO; otherwise a single holding register.

// Fallback values when the shared defines file has not been included ahead of this one.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif
`ifndef DTCM_RAM_AW
`define DTCM_RAM_AW (`DTCM_ADDR_WIDTH-2)
`endif

module dtcm_ctrl (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        dtcm_cmd_valid,
    output logic                        dtcm_cmd_ready,
    input  logic                        dtcm_cmd_read,
    input  logic [`DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr,
    input  logic [`XLEN-1:0]            dtcm_cmd_wdata,
    input  logic [`XLEN/8-1:0]          dtcm_cmd_wmask,
    output logic                        dtcm_rsp_valid,
    input  logic                        dtcm_rsp_ready,
    output logic [`XLEN-1:0]            dtcm_rsp_rdata,
    output logic                        ram_cs,
    output logic                        ram_we,
    output logic [`DTCM_RAM_AW-1:0]     ram_addr,
    output logic [`XLEN/8-1:0]          ram_wem,
    output logic [`XLEN-1:0]            ram_din,
    input  logic [`XLEN-1:0]            ram_dout
);

    localparam int unsigned XLEN            = `XLEN;
    localparam int unsigned DTCM_ADDR_WIDTH = `DTCM_ADDR_WIDTH;
`ifdef DTCM_RSP_FIFO_EN
    localparam int unsigned RSP_DEPTH       = 2;
`else
    localparam int unsigned RSP_DEPTH       = 1;
`endif
    localparam int unsigned CNT_W           = 2;
    localparam int unsigned PTR_W           = 1;

    logic                 cmd_hs;
    logic                 rsp_hs;
    logic [CNT_W-1:0]     cnt;
    logic                 infl_vld;
    logic                 infl_rd;
    logic                 infl_push;
    logic                 buf_head;
    logic                 buf_pop;
    logic [RSP_DEPTH-1:0] buf_vld;
    logic [XLEN-1:0]      buf_data [RSP_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 unused_addr_lsb;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_addr_lsb = ^dtcm_cmd_addr[1:0];

    // Buffered responses are always older than the one in flight, so they go first.
    assign buf_head = buf_vld[rd_ptr];

    always_comb begin
        dtcm_rsp_valid = 1'b0;
        dtcm_rsp_rdata = '0;
        if (buf_head) begin
            dtcm_rsp_valid = 1'b1;
            dtcm_rsp_rdata = buf_data[rd_ptr];
        end else if (infl_vld) begin
            dtcm_rsp_valid = 1'b1;
            dtcm_rsp_rdata = infl_rd ? ram_dout : '0;
        end
    end

    assign rsp_hs         = dtcm_rsp_valid & dtcm_rsp_ready;
    assign dtcm_cmd_ready = (cnt < CNT_W'(RSP_DEPTH)) | rsp_hs;
    // Gated by rst_n so the SRAM stays idle for the whole reset window.
    assign cmd_hs         = dtcm_cmd_valid & dtcm_cmd_ready & rst_n;

    assign ram_cs   = cmd_hs;
    assign ram_we   = cmd_hs & ~dtcm_cmd_read;
    assign ram_addr = dtcm_cmd_addr[DTCM_ADDR_WIDTH-1:2];
    assign ram_wem  = dtcm_cmd_wmask;
    assign ram_din  = dtcm_cmd_wdata;

    // In-flight response that is not taken this cycle drops into the buffer.
    assign infl_push = infl_vld & (buf_head | ~dtcm_rsp_ready);
    assign buf_pop   = buf_head & dtcm_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            infl_vld <= 1'b0;
            infl_rd  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            buf_vld  <= '0;
        end else begin
            infl_vld <= cmd_hs;
            infl_rd  <= dtcm_cmd_read;
            if (cmd_hs && !rsp_hs) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!cmd_hs && rsp_hs) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (infl_push) begin
                buf_vld[wr_ptr] <= 1'b1;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (buf_pop) begin
                buf_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= ptr_inc(rd_ptr);
            end
        end
    end

    // Payload storage needs no reset; the valid flags qualify it.
    always_ff @(posedge clk) begin
        if (infl_push) begin
            buf_data[wr_ptr] <= infl_rd ? ram_dout : '0;
        end
    end

endmodule

// File: doc/dtcm_ctrl.md
DTCM_CTRL -- requirements
Module: dtcm_ctrl

Interface
REQ-001 SHALL take these compile-time values from the shared defines file: XLEN (32, data width), DTCM_ADDR_WIDTH (16, byte address width), DTCM_RAM_AW = DTCM_ADDR_WIDTH-2 (word address width).
REQ-002 SHALL define the local parameter RSP_DEPTH (2 with DTCM_RSP_FIFO_EN, otherwise 1), the maximum number of outstanding responses.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 dtcm_cmd_valid  in  1  LSU command valid.
REQ-006 dtcm_cmd_ready  out  1  command accepted this cycle when high together with valid.
REQ-007 dtcm_cmd_read  in  1  1=load, 0=store.
REQ-008 dtcm_cmd_addr  in  DTCM_ADDR_WIDTH  byte address; bits [1:0] are ignored.
REQ-009 dtcm_cmd_wdata  in  XLEN  store data.
REQ-010 dtcm_cmd_wmask  in  XLEN/8  byte-enable mask for stores.
REQ-011 dtcm_rsp_valid  out  1  response valid.
REQ-012 dtcm_rsp_ready  in  1  LSU accepts the response.
REQ-013 dtcm_rsp_rdata  out  XLEN  load data; 0 for store responses.
REQ-014 ram_cs / ram_we  out  1 / 1  SRAM chip select and write enable.
REQ-015 ram_addr  out  DTCM_RAM_AW  SRAM word address = dtcm_cmd_addr[DTCM_ADDR_WIDTH-1:2].
REQ-016 ram_wem / ram_din  out  XLEN/8 / XLEN  SRAM byte write mask and write data.
REQ-017 ram_dout  in  XLEN  SRAM read data, valid the cycle after a cs with we=0.

Function
REQ-018 A command SHALL be accepted when cmd_valid & cmd_ready; in that same cycle ram_cs=1, ram_we=~cmd_read, and addr/wem/din SHALL be driven combinationally from the command.
REQ-019 ram_cs SHALL be 0 in every cycle with no command handshake.
REQ-020 Every accepted command, load or store, SHALL produce exactly one response; responses SHALL be delivered in acceptance order.
REQ-021 Latency: a command accepted in cycle N SHALL present rsp_valid in cycle N+1 when no older response is pending (flow-through of ram_dout for loads).
REQ-022 If a response is not accepted in the cycle it becomes valid, its data SHALL be captured into the response buffer at the end of that cycle and held stable until accepted.
REQ-023 Occupancy counter cnt (in-flight plus buffered responses) SHALL increment on a command handshake, decrement on a response handshake, and hold when both occur in the same cycle.
REQ-024 cmd_ready SHALL be (cnt < RSP_DEPTH) | (dtcm_rsp_valid & dtcm_rsp_ready); it SHALL NOT depend on cmd_valid.
REQ-025 At full occupancy with no response handshake, cmd_ready=0 and the SRAM SHALL stay idle.
REQ-026 rsp_valid and rsp_rdata SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-027 The buffer read/write pointers SHALL wrap modulo RSP_DEPTH.

Reset
REQ-028 While rst_n=0: cnt=0, pointers=0, buffer valid flags=0, dtcm_rsp_valid=0, dtcm_rsp_rdata=0.
REQ-029 While rst_n=0: ram_cs=0, ram_we=0, and cmd_ready=1 (with cnt=0).
REQ-030 Asserting rst_n mid-transaction SHALL discard all pending responses, with no response emitted after reset is released.

Configuration
REQ-031 Macro DTCM_RSP_FIFO_EN defined: RSP_DEPTH=2, a two-entry response FIFO, and back-to-back commands accepted while one response is stalled.
REQ-032 Macro DTCM_RSP_FIFO_EN undefined: RSP_DEPTH=1, a single holding register, and at most one outstanding command; full throughput only while rsp_ready=1.

Verification
REQ-033 Store addr 0x0010, wdata 0xDEADBEEF, wmask 0xF, then load 0x0010 -> load response rdata 0xDEADBEEF at N+1, store response rdata 0.
REQ-034 Store 0x0010 wdata 0x000000AA wmask 0x1 over 0xDEADBEEF, then load -> rdata 0xDEADBEAA.
REQ-035 Four back-to-back loads with rsp_ready=1 -> one response per cycle, in order, cmd_ready constantly 1.
REQ-036 rsp_ready=0 for 5 cycles with cmd_valid=1 -> exactly RSP_DEPTH commands accepted, then cmd_ready=0; rdata stable; on release all responses are delivered in order.
REQ-037 rst_n pulsed low while cnt=2 -> rsp_valid=0 immediately, cnt=0, and no stale response after release.
REQ-038 At full occupancy, assert rsp_ready and cmd_valid together -> same-cycle handshake on both, cnt unchanged.
